// File: rtl/prescale_blink_bank.sv
`default_nettype none
// ============================================================================
// prescale_blink_bank : shared power-of-two prescaler driving N blink channels
// Rev 1.0
// ============================================================================
module prescale_blink_bank #(
  parameter int unsigned PRESCALE_W = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned BLINK_W    = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [PRESCALE_W-1:0]   sel_i,
  input  logic                    load_i,
  input  logic [CHANNELS-1:0]     chan_en_i,
  input  logic [2*CHANNELS-1:0]   mode_i,
  output logic                    tick_o,
  output logic [CHANNELS-1:0]     blink_o,
  output logic [CHANNELS-1:0]     wrap_o
);

  localparam logic [1:0] MODE_TOGGLE  = 2'b00;
  localparam logic [1:0] MODE_PULSE   = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_OFF     = 2'b11;

  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [PRESCALE_W-1:0] sel_q, sel_d;
  logic                  tick_q, tick_d;
  logic [PRESCALE_W-1:0] tick_mask;

  // The highest set bit of sel_q wins, so later loop iterations override earlier ones.
  always_comb begin
    tick_mask = '0;
    for (int i = 0; i < PRESCALE_W; i++) begin
      if (sel_q[i]) tick_mask = {PRESCALE_W{1'b1}} >> (PRESCALE_W - i);
    end
  end

  always_comb begin
    sel_d  = sel_q;
    p_d    = p_q + PRESCALE_W'(1);
    if (load_i) begin
      sel_d = sel_i;
      p_d   = '0;
    end
    tick_d = (sel_q != '0) && ((p_q & tick_mask) == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q    <= '0;
      sel_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      sel_q  <= sel_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_chan
      logic [BLINK_W-1:0] cnt_q, cnt_d;
      logic [1:0]         mode_q;
      logic               blink_q, blink_d;
      logic               wrap_q, wrap_d;
      logic [1:0]         mode_in;

      assign mode_in = mode_i[2*c +: 2];

      // A mode change outranks the enable and any tick landing in the same cycle.
      always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if ((mode_q != mode_in) || !chan_en_i[c] || (mode_q == MODE_OFF)) begin
          cnt_d = '0;
        end else if (tick_q) begin
          if (mode_q == MODE_ONESHOT) begin
            if (!cnt_q[BLINK_W-1]) cnt_d = cnt_q + BLINK_W'(1);
          end else begin
            cnt_d  = cnt_q + BLINK_W'(1);
            wrap_d = &cnt_q;
          end
        end
        blink_d = (mode_q == MODE_PULSE) ? wrap_d : cnt_d[BLINK_W-1];
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q   <= '0;
          mode_q  <= MODE_TOGGLE;
          blink_q <= 1'b0;
          wrap_q  <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          mode_q  <= mode_in;
          blink_q <= blink_d;
          wrap_q  <= wrap_d;
        end
      end

      assign blink_o[c] = blink_q;
      assign wrap_o[c]  = wrap_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_prescale_blink_bank.sv
`default_nettype none
// ============================================================================
// tb_prescale_blink_bank : directed checks of prescaler and channel modes
// Rev 1.0
// ============================================================================
module tb_prescale_blink_bank;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] sel_i;
  logic       load_i;
  logic [3:0] chan_en_i;
  logic [7:0] mode_i;
  logic       tick_o;
  logic [3:0] blink_o;
  logic [3:0] wrap_o;

  int checks = 0;
  int errors = 0;

  prescale_blink_bank #(
    .PRESCALE_W(8),
    .CHANNELS  (4),
    .BLINK_W   (4)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sel_i    (sel_i),
    .load_i   (load_i),
    .chan_en_i(chan_en_i),
    .mode_i   (mode_i),
    .tick_o   (tick_o),
    .blink_o  (blink_o),
    .wrap_o   (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i  = 1'b1;
    load_i = 1'b0;
    step();
    rst_i  = 1'b0;
  endtask

  // Load sel, then advance one more edge: counting starts at the edge after that.
  task automatic load_sel(input logic [7:0] s);
    sel_i  = s;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    bit seen;
    rst_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sel_i     = 8'($urandom);
      load_i    = 1'($urandom);
      chan_en_i = 4'($urandom);
      mode_i    = 8'($urandom);
      step();
      checks++;
      if ({tick_o, blink_o, wrap_o} !== 9'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got tick=%b blink=%b wrap=%b want all 0",
                 i, tick_o, blink_o, wrap_o);
      end
    end
    rst_i  = 1'b0;
    load_i = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      sel_i     = 8'($urandom);
      chan_en_i = 4'($urandom);
      step();
      if (tick_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_sel0_idle got tick seen=%b want 0", seen);
    end
  endtask

  task automatic check_period(input string name, input int period, input int edges);
    for (int i = 2; i <= edges; i++) begin
      step();
      checks++;
      if (tick_o !== (((i - 1) % period) == 0)) begin
        errors++;
        $display("FAIL %s edge=%0d got tick=%b want %b", name, i, tick_o,
                 (((i - 1) % period) == 0));
      end
    end
  endtask

  task automatic test_divide();
    do_reset();
    chan_en_i = 4'b0;
    mode_i    = 8'b0;
    sel_i     = 8'h01;
    load_i    = 1'b1;
    step();
    load_i = 1'b0;
    checks++;
    if (tick_o !== 1'b0) begin
      errors++;
      $display("FAIL div1_load_edge got tick=%b want 0", tick_o);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (tick_o !== 1'b1) begin
        errors++;
        $display("FAIL div1_every_cycle cyc=%0d got tick=%b want 1", i, tick_o);
      end
    end
    load_sel(8'h08);
    checks++;
    if (tick_o !== 1'b1) begin
      errors++;
      $display("FAIL div8_first got tick=%b want 1", tick_o);
    end
    sel_i = 8'h01;  // no load: must be ignored
    check_period("div8_period", 8, 25);
    load_sel(8'h88);
    checks++;
    if (tick_o !== 1'b1) begin
      errors++;
      $display("FAIL div88_first got tick=%b want 1", tick_o);
    end
    check_period("div88_period", 128, 260);
  endtask

  task automatic test_toggle();
    do_reset();
    chan_en_i = 4'b0001;
    mode_i    = 8'b0;
    load_sel(8'h01);
    for (int n = 1; n <= 40; n++) begin
      step();
      checks++;
      if (blink_o[0] !== ((n % 16) >= 8) || wrap_o[0] !== ((n % 16) == 0)) begin
        errors++;
        $display("FAIL toggle n=%0d got blink=%b wrap=%b want blink=%b wrap=%b",
                 n, blink_o[0], wrap_o[0], ((n % 16) >= 8), ((n % 16) == 0));
      end
    end
  endtask

  task automatic test_pulse_oneshot();
    logic pulse;
    do_reset();
    chan_en_i = 4'b0110;
    mode_i    = 8'b00_10_01_00;
    load_sel(8'h01);
    for (int n = 1; n <= 40; n++) begin
      step();
      pulse = (n % 16) == 0;
      checks++;
      if (blink_o[1] !== pulse || wrap_o[1] !== pulse || blink_o[2] !== (n >= 8) ||
          wrap_o[2] !== 1'b0) begin
        errors++;
        $display("FAIL pulse_oneshot n=%0d got blink=%b wrap=%b want b1=%b w1=%b b2=%b w2=0",
                 n, blink_o, wrap_o, pulse, pulse, (n >= 8));
      end
    end
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (blink_o[2] !== 1'b1 || wrap_o[2] !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_hold cyc=%0d got blink2=%b wrap2=%b want 1/0",
                 i, blink_o[2], wrap_o[2]);
      end
    end
    chan_en_i[2] = 1'b0;
    step();
    checks++;
    if (blink_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_disable got blink2=%b want 0", blink_o[2]);
    end
  endtask

  task automatic test_mid_events();
    do_reset();
    chan_en_i = 4'b0001;
    mode_i    = 8'b0;
    load_sel(8'h01);
    for (int n = 1; n <= 5; n++) step();
    mode_i = 8'b00_00_00_10;  // ch0 to ONESHOT while tick is high
    step();
    checks++;
    if (blink_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL mode_change_clear got blink0=%b want 0", blink_o[0]);
    end
    for (int i = 1; i <= 7; i++) step();
    checks++;
    if (blink_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL mode_change_no_inc at7 got blink0=%b want 0", blink_o[0]);
    end
    step();
    checks++;
    if (blink_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL mode_change_no_inc at8 got blink0=%b want 1", blink_o[0]);
    end
    rst_i = 1'b1;
    step();
    checks++;
    if ({tick_o, blink_o, wrap_o} !== 9'b0) begin
      errors++;
      $display("FAIL mid_reset got tick=%b blink=%b wrap=%b want all 0",
               tick_o, blink_o, wrap_o);
    end
    sel_i  = 8'h01;
    load_i = 1'b1;
    step();
    rst_i  = 1'b0;
    load_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (tick_o !== 1'b0 || blink_o !== 4'b0) begin
        errors++;
        $display("FAIL reset_over_load cyc=%0d got tick=%b blink=%b want 0/0000",
                 i, tick_o, blink_o);
      end
    end
  endtask

  task automatic test_independence();
    logic [3:0] exp_b, exp_w;
    do_reset();
    chan_en_i = 4'b1110;
    mode_i    = 8'b11_10_01_00;
    load_sel(8'h01);
    for (int n = 1; n <= 40; n++) begin
      step();
      exp_w = {2'b00, ((n % 16) == 0), 1'b0};
      exp_b = {1'b0, (n >= 8), ((n % 16) == 0), 1'b0};
      checks++;
      if (blink_o !== exp_b || wrap_o !== exp_w) begin
        errors++;
        $display("FAIL independence n=%0d got blink=%b wrap=%b want blink=%b wrap=%b",
                 n, blink_o, wrap_o, exp_b, exp_w);
      end
    end
  endtask

  initial begin
    rst_i     = 1'b1;
    sel_i     = 8'h00;
    load_i    = 1'b0;
    chan_en_i = 4'b0;
    mode_i    = 8'b0;
    test_reset();
    test_divide();
    test_toggle();
    test_pulse_oneshot();
    test_mid_events();
    test_independence();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
